// File: rtl/sym_clk_gen.sv
// Symbol clock generator: divides clk by a programmable ratio, producing a
// bit-rate tick, a toggling divided clock and a dibit (QPSK symbol) strobe.
// New ratios are staged in a pending register and take effect only at a
// terminal count or a synchronous restart, so a period is never cut short.
module sym_clk_gen #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] div_ratio,
  output logic             c_out,
  output logic             tick,
  output logic             sym_tick,
  output logic             sym_phase,
  output logic             f_valid
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_v;
  logic             r_c_out;
  logic             r_tick;
  logic             r_sym_tick;
  logic             r_sym_phase;
  logic             r_f_valid;

  logic [CNT_W-1:0] w_clamp;
  logic             w_term;

  // Ratios below 2 cannot form a period, so they are raised to 2.
  always_comb begin
    w_clamp = (div_ratio < CNT_W'(2)) ? CNT_W'(2) : div_ratio;
    w_term  = en & ~sync & (r_count == r_div);
  end

  // Divider, ratio staging and symbol-phase state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= CNT_W'(1);
      r_div       <= CNT_W'(DEFAULT_DIV);
      r_pend      <= '0;
      r_pend_v    <= 1'b0;
      r_c_out     <= 1'b0;
      r_tick      <= 1'b0;
      r_sym_tick  <= 1'b0;
      r_sym_phase <= 1'b0;
      r_f_valid   <= 1'b0;
    end else if (sync) begin
      // Restart: a ratio offered now wins over one already pending.
      r_count     <= CNT_W'(1);
      r_c_out     <= 1'b0;
      r_tick      <= 1'b0;
      r_sym_tick  <= 1'b0;
      r_sym_phase <= 1'b0;
      r_f_valid   <= 1'b0;
      r_pend_v    <= 1'b0;
      if (load)          r_div <= w_clamp;
      else if (r_pend_v) r_div <= r_pend;
    end else if (w_term) begin
      // End of period: new ratio (if any) governs the next period.
      r_count     <= CNT_W'(1);
      r_c_out     <= ~r_c_out;
      r_tick      <= 1'b1;
      r_sym_tick  <= r_sym_phase;
      r_sym_phase <= ~r_sym_phase;
      r_f_valid   <= 1'b1;
      if (load) begin
        r_div    <= w_clamp;
        r_pend_v <= 1'b0;
      end else if (r_pend_v) begin
        r_div    <= r_pend;
        r_pend_v <= 1'b0;
      end
    end else begin
      // Mid-period (running or paused): stage any load for later.
      if (en) r_count <= r_count + CNT_W'(1);
      r_tick     <= 1'b0;
      r_sym_tick <= 1'b0;
      if (load) begin
        r_pend   <= w_clamp;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign c_out     = r_c_out;
  assign tick      = r_tick;
  assign sym_tick  = r_sym_tick;
  assign sym_phase = r_sym_phase;
  assign f_valid   = r_f_valid;

endmodule

// File: tb/tb_sym_clk_gen.sv
// Bench for sym_clk_gen: directed scenarios followed by random traffic,
// compared every cycle against a period/tick-count reference model.
module tb_sym_clk_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, sync, load;
  logic [7:0] div_ratio;
  logic       c_out, tick, sym_tick, sym_phase, f_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: how many enabled edges into the current period,
  // how long the period is, how many ticks since restart, and an
  // optional staged ratio.
  int m_elapsed, m_period, m_ntick, m_pend;
  bit m_pend_v, m_tick;

  sym_clk_gen #(.CNT_W(8), .DEFAULT_DIV(50)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .load(load),
    .div_ratio(div_ratio), .c_out(c_out), .tick(tick),
    .sym_tick(sym_tick), .sym_phase(sym_phase), .f_valid(f_valid)
  );

  always #5 clk = ~clk;

  function automatic int clampf(int r);
    return (r < 2) ? 2 : r;
  endfunction

  task automatic model_reset();
    m_elapsed = 0; m_period = 50; m_ntick = 0;
    m_pend = 0; m_pend_v = 0; m_tick = 0;
  endtask

  task automatic model_edge(input bit e, input bit s, input bit l, input int r);
    m_tick = 0;
    if (s) begin
      m_elapsed = 0; m_ntick = 0;
      if (l) m_period = clampf(r);
      else if (m_pend_v) m_period = m_pend;
      m_pend_v = 0;
    end else if (e && (m_elapsed + 1 == m_period)) begin
      m_elapsed = 0; m_ntick++; m_tick = 1;
      if (l) m_period = clampf(r);
      else if (m_pend_v) m_period = m_pend;
      m_pend_v = 0;
    end else begin
      if (e) m_elapsed++;
      if (l) begin m_pend = clampf(r); m_pend_v = 1; end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_tick"},      tick,      m_tick);
    chk({tag, "_sym_tick"},  sym_tick,  m_tick && (m_ntick % 2 == 0));
    chk({tag, "_c_out"},     c_out,     m_ntick[0]);
    chk({tag, "_sym_phase"}, sym_phase, m_ntick[0]);
    chk({tag, "_f_valid"},   f_valid,   m_ntick > 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tick"},      tick,      1'b0);
    chk({tag, "_sym_tick"},  sym_tick,  1'b0);
    chk({tag, "_c_out"},     c_out,     1'b0);
    chk({tag, "_sym_phase"}, sym_phase, 1'b0);
    chk({tag, "_f_valid"},   f_valid,   1'b0);
  endtask

  // One clock: drive inputs, take the edge, advance model, check at +1.
  task automatic step(input string tag, input bit e, input bit s,
                      input bit l, input int r);
    en = e; sync = s; load = l; div_ratio = r[7:0];
    @(posedge clk);
    model_edge(e, s, l, r);
    #1;
    chk_model(tag);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sync = 1'b0; load = 1'b0; div_ratio = '0;
    model_reset();
    #1;
    chk_zero("reset");
    repeat (3) begin
      @(posedge clk); #1;
      chk_zero("reset_hold");
    end
    @(negedge clk);
    rst = 1'b1;

    // Free run at the default ratio: ticks at edge multiples of 50.
    for (int e = 1; e <= 210; e++) begin
      step("dflt", 1, 0, 0, 0);
      chk("dflt_tick_edge", tick, (e % 50) == 0);
      chk("dflt_symtick_edge", sym_tick, (e % 100) == 0);
    end

    // Load 4 at count 20: current period completes first.
    repeat (9) step("ld4_pre", 1, 0, 0, 0);
    step("ld4_load", 1, 0, 1, 4);
    for (int e = 1; e <= 62; e++) step("ld4_run", 1, 0, 0, 0);

    // Clamp: 1 and 0 both behave as 2.
    step("ld1_load", 1, 0, 1, 1);
    repeat (20) step("ld1_run", 1, 0, 0, 0);
    step("ld0_load", 1, 0, 1, 0);
    repeat (20) step("ld0_run", 1, 0, 0, 0);

    // Pause for 7 cycles mid-period at ratio 50.
    step("sync50", 1, 1, 1, 50);
    repeat (29) step("pause_pre", 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step("pause", 0, 0, 0, 0);
      chk("pause_tick", tick, 1'b0);
    end
    repeat (40) step("pause_post", 1, 0, 0, 0);

    // Sync with load 6 mid-period.
    repeat (13) step("sync6_pre", 1, 0, 0, 0);
    step("sync6", 1, 1, 1, 6);
    chk("sync6_c_out", c_out, 1'b0);
    chk("sync6_f_valid", f_valid, 1'b0);
    chk("sync6_sym_phase", sym_phase, 1'b0);
    repeat (30) step("sync6_run", 1, 0, 0, 0);

    // Async reset while a ratio is pending: pending value is discarded.
    step("pend9", 1, 0, 1, 9);
    repeat (2) step("pend9_run", 1, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_zero("async_rst");
    #2 rst = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step("post_rst", 1, 0, 0, 0);
      chk("post_rst_tick_edge", tick, e == 50);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit e, s, l;
      int r;
      e = ($urandom_range(99) < 85);
      s = ($urandom_range(99) < 2);
      l = ($urandom_range(99) < 6);
      r = ($urandom_range(9) == 0) ? int'($urandom_range(255))
                                   : int'($urandom_range(12));
      step("rand", e, s, l, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
